// File: rtl/hpi_bus_arbiter.sv
// HPI bus arbiter: shares the CY7C67200 host-port interface between two
// requesters and sequences each access as a timed CS/strobe cycle.
module hpi_bus_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_addr,
  input  logic [15:0] r0_wdata,
  output logic        r0_ack,
  output logic [15:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r1_ack,
  output logic [15:0] r1_rdata,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic [15:0] hpi_dout,
  output logic        hpi_dout_en,
  input  logic [15:0] hpi_din
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ACK, TURN
  } state_t;

  localparam logic [2:0] SETUP_L  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_L = 3'(STROBE_CYC - 1);
  localparam logic [2:0] HOLD_L   = 3'(HOLD_CYC - 1);
  localparam logic [2:0] TURN_L   = 3'(TURN_CYC - 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        last_q;
  logic        gnt_q;
  logic        we_q;
  logic [15:0] rd_q;
  logic [1:0]  addr_q;
  logic        cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        den_q;
  logic [15:0] dout_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;

  logic        gnt_d;
  logic        we_d;
  logic [1:0]  addr_d;
  logic [15:0] wdata_d;
  logic        fin_d;
  logic [15:0] rdata_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_d = 1'b0;
    priority case (1'b1)
      r0_req && r1_req: gnt_d = ~last_q;
      r1_req:           gnt_d = 1'b1;
      default:          gnt_d = 1'b0;
    endcase
  end

  assign we_d    = gnt_d ? r1_we    : r0_we;
  assign addr_d  = gnt_d ? r1_addr  : r0_addr;
  assign wdata_d = gnt_d ? r1_wdata : r0_wdata;

  // With no HOLD phase the strobe end goes straight to ACK using live data.
  always_comb begin
    fin_d   = 1'b0;
    rdata_d = rd_q;
    if (state_q == STROBE && cnt_q == STROBE_L && HOLD_CYC == 0) begin
      fin_d   = 1'b1;
      rdata_d = hpi_din;
    end
    if (state_q == HOLD && cnt_q == HOLD_L)
      fin_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      addr_q   <= '0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      den_q    <= 1'b0;
      dout_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (r0_req || r1_req) begin
            state_q <= SETUP;
            cnt_q   <= '0;
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cs_n_q  <= 1'b0;
            if (we_d) begin
              dout_q <= wdata_d;
              den_q  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_L) begin
            state_q <= STROBE;
            cnt_q   <= '0;
            rd_n_q  <= we_q;
            wr_n_q  <= ~we_q;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        STROBE: begin
          if (cnt_q == STROBE_L) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_q    <= hpi_din;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        HOLD: cnt_q <= cnt_q + 3'd1;
        ACK: begin
          state_q <= (TURN_CYC == 0) ? IDLE : TURN;
          cnt_q   <= '0;
        end
        TURN: begin
          if (cnt_q == TURN_L) state_q <= IDLE;
          else                 cnt_q   <= cnt_q + 3'd1;
        end
        default: state_q <= IDLE;
      endcase
      if (fin_d) begin
        state_q <= ACK;
        cs_n_q  <= 1'b1;
        den_q   <= 1'b0;
        ack0_q  <= ~gnt_q;
        ack1_q  <= gnt_q;
        if (!we_q) begin
          if (gnt_q) rdata1_q <= rdata_d;
          else       rdata0_q <= rdata_d;
        end
      end
    end
  end

  assign hpi_addr    = addr_q;
  assign hpi_cs_n    = cs_n_q;
  assign hpi_rd_n    = rd_n_q;
  assign hpi_wr_n    = wr_n_q;
  assign hpi_dout    = dout_q;
  assign hpi_dout_en = den_q;
  assign r0_ack      = ack0_q;
  assign r1_ack      = ack1_q;
  assign r0_rdata    = rdata0_q;
  assign r1_rdata    = rdata1_q;

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// Bench for hpi_bus_arbiter: scoreboarded directed and random accesses,
// bus protocol monitor, and a HOLD=0/TURN=0 instance.
module tb_hpi_bus_arbiter;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk, reset;
  logic r0_req, r0_we, r0_ack, r1_req, r1_we, r1_ack;
  logic [1:0] r0_addr, r1_addr, hpi_addr;
  logic [15:0] r0_wdata, r0_rdata, r1_wdata, r1_rdata;
  logic hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout_en;
  logic [15:0] hpi_dout, hpi_din;

  logic f_req, f_we, f_ack, f1_req, f1_we, f1_ack;
  logic [1:0] f_addr, f1_addr, f_haddr;
  logic [15:0] f_wdata, f_rdata, f1_wdata, f1_rdata;
  logic f_cs_n, f_rd_n, f_wr_n, f_den;
  logic [15:0] f_dout, f_din;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acks = 0;
  int grants = 0;
  int strb_n = 0;
  int den_n = 0;
  int cs_cyc = 0;
  bit prev_cs = 1;
  logic [1:0] s_addr;
  logic s_we;
  logic [15:0] s_dout;
  logic [15:0] mdl0, mdl1;
  exp_t sb0[$];
  exp_t sb1[$];
  bit ack_log[$];
  int ack_cyc[$];
  logic [15:0] fq[$];

  function automatic logic [15:0] dev(input logic [1:0] a);
    return 16'hBEEF ^ ({14'b0, a ^ 2'd2} * 16'h1111);
  endfunction

  assign hpi_din = dev(hpi_addr);
  assign f_din   = dev(f_haddr);

  hpi_bus_arbiter u_dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
    .hpi_wr_n(hpi_wr_n), .hpi_dout(hpi_dout),
    .hpi_dout_en(hpi_dout_en), .hpi_din(hpi_din)
  );

  hpi_bus_arbiter #(
    .SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(0), .TURN_CYC(0)
  ) u_fast (
    .clk(clk), .reset(reset),
    .r0_req(f_req), .r0_we(f_we), .r0_addr(f_addr),
    .r0_wdata(f_wdata), .r0_ack(f_ack), .r0_rdata(f_rdata),
    .r1_req(f1_req), .r1_we(f1_we), .r1_addr(f1_addr),
    .r1_wdata(f1_wdata), .r1_ack(f1_ack), .r1_rdata(f1_rdata),
    .hpi_addr(f_haddr), .hpi_cs_n(f_cs_n), .hpi_rd_n(f_rd_n),
    .hpi_wr_n(f_wr_n), .hpi_dout(f_dout),
    .hpi_dout_en(f_den), .hpi_din(f_din)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit id;
    bit have;
    logic viol;
    logic [15:0] got;
    if (reset) begin
      strb_n  = 0;
      den_n   = 0;
      prev_cs = 1;
      mdl0    = '0;
      mdl1    = '0;
    end else begin
      viol = (!hpi_rd_n && !hpi_wr_n) ||
             ((!hpi_rd_n || !hpi_wr_n) && hpi_cs_n);
      chk("proto", 32'(viol), 0);
      if (prev_cs && !hpi_cs_n) begin
        grants++;
        cs_cyc = cyc;
      end
      prev_cs = hpi_cs_n;
      if (!hpi_rd_n || !hpi_wr_n) begin
        strb_n++;
        s_addr = hpi_addr;
        s_we   = !hpi_wr_n;
        s_dout = hpi_dout;
      end
      if (hpi_dout_en) den_n++;
      if (r0_ack || r1_ack) begin
        chk("ack_excl", 32'(r0_ack & r1_ack), 0);
        id = r1_ack;
        acks++;
        ack_log.push_back(id);
        ack_cyc.push_back(cyc);
        chk("latency", 32'(cyc - cs_cyc), 6);
        chk("strobe_len", 32'(strb_n), 4);
        have = id ? (sb1.size() > 0) : (sb0.size() > 0);
        chk("ack_expected", 32'(have), 1);
        if (have) begin
          e = id ? sb1.pop_front() : sb0.pop_front();
          got = id ? r1_rdata : r0_rdata;
          chk("addr", 32'(s_addr), 32'(e.addr));
          chk("we", 32'(s_we), 32'(e.we));
          if (e.we) begin
            chk("dout", 32'(s_dout), 32'(e.wdata));
            chk("dout_en_len", 32'(den_n), 6);
            chk("rdata_keep", 32'(got), 32'(id ? mdl1 : mdl0));
          end else begin
            chk("dout_en_rd", 32'(den_n), 0);
            chk("rdata", 32'(got), 32'(e.rdata));
            if (id) mdl1 = e.rdata;
            else    mdl0 = e.rdata;
          end
          chk("rdata_other", 32'(id ? r0_rdata : r1_rdata),
              32'(id ? mdl0 : mdl1));
        end
        strb_n = 0;
        den_n  = 0;
      end
    end
  end

  task automatic access(input bit id, input logic we, input logic [1:0] a,
                        input logic [15:0] wd);
    exp_t e;
    bit got;
    e.we = we;
    e.addr = a;
    e.wdata = wd;
    e.rdata = we ? 16'h0 : dev(a);
    if (id) begin
      sb1.push_back(e);
      r1_we = we; r1_addr = a; r1_wdata = wd; r1_req = 1;
    end else begin
      sb0.push_back(e);
      r0_we = we; r0_addr = a; r0_wdata = wd; r0_req = 1;
    end
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      tick();
      if (id ? r1_ack : r0_ack) got = 1;
    end
    chk("ack_wait", 32'(got), 1);
    if (id) r1_req = 0;
    else    r0_req = 0;
  endtask

  initial begin
    int a0, g0, b, n;
    int fcs[$];
    int fak[$];
    bit fprev;
    reset = 1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    f_req = 0; f_we = 0; f_addr = 0; f_wdata = 0;
    f1_req = 0; f1_we = 0; f1_addr = 0; f1_wdata = 0;
    repeat (3) tick();
    chk("rst_cs_n", 32'(hpi_cs_n), 1);
    chk("rst_rd_n", 32'(hpi_rd_n), 1);
    chk("rst_wr_n", 32'(hpi_wr_n), 1);
    chk("rst_dout_en", 32'(hpi_dout_en), 0);
    chk("rst_addr", 32'(hpi_addr), 0);
    chk("rst_dout", 32'(hpi_dout), 0);
    chk("rst_acks", 32'({r0_ack, r1_ack}), 0);
    chk("rst_rdata0", 32'(r0_rdata), 0);
    chk("rst_rdata1", 32'(r1_rdata), 0);
    reset = 0;
    tick();

    access(1'b0, 1'b0, 2'd2, 16'h0);
    chk("read_beef", 32'(r0_rdata), 32'h0000BEEF);
    repeat (3) tick();
    access(1'b1, 1'b1, 2'd1, 16'h1234);
    repeat (3) tick();

    a0 = acks;
    g0 = grants;
    fork
      repeat (8) begin
        repeat ($urandom_range(0, 3)) tick();
        access(1'b0, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 16'($urandom));
      end
      repeat (8) begin
        repeat ($urandom_range(0, 3)) tick();
        access(1'b1, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 16'($urandom));
      end
    join
    repeat (12) tick();
    chk("rand_acks", 32'(acks - a0), 16);
    chk("grant_per_ack", 32'(acks - a0), 32'(grants - g0));

    r0_we = 1; r0_addr = 2'd1; r0_wdata = 16'h0F0F; r0_req = 1;
    n = 0;
    while (n < 30 && !(strb_n == 2 && !hpi_wr_n)) begin
      tick();
      n++;
    end
    chk("rst_reach_strobe2", 32'(n < 30), 1);
    reset = 1;
    #1;
    chk("rst_mid_wr_n", 32'(hpi_wr_n), 1);
    chk("rst_mid_cs_n", 32'(hpi_cs_n), 1);
    chk("rst_mid_dout_en", 32'(hpi_dout_en), 0);
    chk("rst_mid_ack", 32'(r0_ack), 0);
    chk("rst_mid_fsm", 32'(u_dut.state_q), 0);
    r0_req = 0;
    tick();
    reset = 0;
    tick();
    a0 = acks;
    repeat (12) tick();
    chk("rst_no_ack", 32'(acks - a0), 0);
    chk("rst_rdata_clr", 32'({r0_rdata, r1_rdata}), 0);

    b = ack_log.size();
    a0 = acks;
    for (int k = 0; k < 2; k++) begin
      sb0.push_back('{we: 1'b0, addr: 2'd3, wdata: 16'h0, rdata: dev(2'd3)});
      sb1.push_back('{we: 1'b1, addr: 2'd0, wdata: 16'h5A5A, rdata: 16'h0});
    end
    r0_we = 0; r0_addr = 2'd3; r0_wdata = 16'h0;
    r1_we = 1; r1_addr = 2'd0; r1_wdata = 16'h5A5A;
    r0_req = 1; r1_req = 1;
    n = 0;
    while (n < 80 && acks - a0 < 4) begin
      tick();
      n++;
    end
    r0_req = 0; r1_req = 0;
    chk("rr_acks", 32'(acks - a0), 4);
    if (ack_log.size() >= b + 4) begin
      for (int k = 0; k < 4; k++)
        chk("rr_order", 32'(ack_log[b+k]), 32'(k % 2));
      for (int k = 0; k < 3; k++)
        chk("rr_gap", 32'(ack_cyc[b+k+1] - ack_cyc[b+k]), 10);
    end
    repeat (12) tick();

    fq.push_back(dev(2'd1));
    fq.push_back(dev(2'd1));
    f_we = 0; f_addr = 2'd1; f_req = 1;
    fprev = 1;
    n = 0;
    while (n < 80 && fak.size() < 2) begin
      tick();
      n++;
      if (fprev && !f_cs_n) fcs.push_back(n);
      fprev = f_cs_n;
      if (f_ack) begin
        fak.push_back(n);
        if (fq.size() > 0) chk("f_rdata", 32'(f_rdata), 32'(fq.pop_front()));
        if (fak.size() == 2) f_req = 0;
      end
    end
    f_req = 0;
    chk("f_acks", 32'(fak.size()), 2);
    if (fak.size() == 2 && fcs.size() >= 2) begin
      chk("f_latency", 32'(fak[0] - fcs[0]), 5);
      chk("f_b2b_cs", 32'(fcs[1] - fak[0]), 2);
    end
    chk("f_rdata1", 32'(f1_rdata), 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
